compute_seq: RTL and testbench

Control sequencer that sits directly upstream of the compute unit and drives its accumulator, adder-tree and SIPO controls. It consumes operand beats from the operand buffer through a valid/ready handshake. For each reduced output it runs `num_acc` MAC passes: the first pass takes the external addend, later passes take the accumulator. On the final pass it strobes the adder tree and SIPO, repeats this `num_out` times, then pulses `done`, at which point `dldA` holds the collected vector.

---
 rtl/compute_seq_if.sv | 47 ++++
 rtl/compute_seq.sv | 139 +++++++++++++
 tb/tb_compute_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/compute_seq_if.sv
// compute_seq_if -- launch, operand handshake and compute-unit control bundle
// for the compute sequencer.
//
//   master (sequencer side)
//     in : start, abort, num_acc, num_out, op_valid
//     out: op_ready, acc_idx, out_idx, rst_accm_b, accm_en, mux_accm_inp,
//          en_adder_tree, sipo_shift, busy, done
//   slave (launcher / operand buffer / compute unit side): the mirror image.
interface compute_seq_if #(
  parameter int COUNT = 128,
  parameter int ACC_W = 8,
  parameter int OUT_W = $clog2(COUNT) + 1
);
  localparam int IDX_W = $clog2(COUNT);

  // launch
  logic             start;
  logic             abort;
  logic [ACC_W-1:0] num_acc;
  logic [OUT_W-1:0] num_out;
  // operand handshake
  logic             op_valid;
  logic             op_ready;
  logic [ACC_W-1:0] acc_idx;
  logic [IDX_W-1:0] out_idx;
  // compute unit controls
  logic             rst_accm_b;
  logic             accm_en;
  logic             mux_accm_inp;
  logic             en_adder_tree;
  logic             sipo_shift;
  // status
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, num_acc, num_out, op_valid,
    output op_ready, acc_idx, out_idx, rst_accm_b, accm_en, mux_accm_inp,
           en_adder_tree, sipo_shift, busy, done
  );

  modport slave (
    output start, abort, num_acc, num_out, op_valid,
    input  op_ready, acc_idx, out_idx, rst_accm_b, accm_en, mux_accm_inp,
           en_adder_tree, sipo_shift, busy, done
  );
endinterface

// File: rtl/compute_seq.sv
// compute_seq -- control sequencer in front of the compute unit.
//
// For every reduced output it runs na MAC passes over operand beats from the
// operand buffer (first pass selects the external addend, later passes the
// accumulator feedback). The final pass of each output strobes the adder tree
// and the SIPO; after no outputs it pulses done.
//
// Ports
//   clk    : clock, all state on the rising edge
//   rst_b  : asynchronous active-low reset
//   bus    : compute_seq_if.master (launch, operand handshake, controls)
module compute_seq #(
  parameter int COUNT = 128,
  parameter int ACC_W = 8,
  parameter int OUT_W = $clog2(COUNT) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  compute_seq_if.master bus
);

  localparam int IDX_W = $clog2(COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_idx_q;
  logic [IDX_W-1:0] out_idx_q;
  // Latched as "last index" (effective count - 1) so end-of-pass and
  // end-of-run are plain equality compares against the running counters.
  logic [ACC_W-1:0] acc_last_q, acc_last_in;
  logic [IDX_W-1:0] out_last_q, out_last_in;
  logic             rst_accm_b_q;

  logic run, beat, last_pass, last_out, launch;
  logic accm_en, mux_accm_inp, tree_en;

  // Effective parameters: 0 runs as 1, num_out above COUNT clamps to COUNT.
  always_comb begin
    acc_last_in = '0;
    out_last_in = '0;
    if (bus.num_acc != '0)
      acc_last_in = bus.num_acc - ACC_W'(1);
    if (bus.num_out > OUT_W'(COUNT))
      out_last_in = IDX_W'(COUNT - 1);
    else if (bus.num_out != '0)
      out_last_in = IDX_W'(bus.num_out - OUT_W'(1));
  end

  assign run       = (state_q == S_RUN);
  assign beat      = run && bus.op_valid;
  assign last_pass = (acc_idx_q == acc_last_q);
  assign last_out  = (out_idx_q == out_last_q);
  // Start is only looked at in IDLE, and abort beats it.
  assign launch    = (state_q == S_IDLE) && bus.start && !bus.abort;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and control strobes
  always_comb begin
    state_d      = state_q;
    accm_en      = 1'b0;
    mux_accm_inp = 1'b0;
    tree_en      = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        accm_en      = beat;
        mux_accm_inp = (acc_idx_q != '0);
        tree_en      = beat && last_pass;
        if (beat && last_pass && last_out) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  // Pass / output counters. Cleared on the way into CLEAR and on abort; they
  // only move on a beat, so an op_valid-low cycle holds them.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_idx_q <= '0;
      out_idx_q <= '0;
    end else if (bus.abort || ((state_q == S_IDLE) && bus.start)) begin
      acc_idx_q <= '0;
      out_idx_q <= '0;
    end else if (beat) begin
      if (last_pass) begin
        acc_idx_q <= '0;
        // Final beat of the run parks out_idx at 0 rather than wrapping.
        out_idx_q <= last_out ? '0 : out_idx_q + IDX_W'(1);
      end else begin
        acc_idx_q <= acc_idx_q + ACC_W'(1);
      end
    end
  end

  // Parameters held for the whole run; start pulses while busy never reach here.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_last_q <= '0;
      out_last_q <= '0;
    end else if (launch) begin
      acc_last_q <= acc_last_in;
      out_last_q <= out_last_in;
    end
  end

  // Accumulator clear comes straight from a flop that tracks "next state is
  // RUN or DONE", so the compute unit never sees a decode glitch on it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rst_accm_b_q <= 1'b0;
    else        rst_accm_b_q <= (state_d == S_RUN) || (state_d == S_DONE);
  end

  assign bus.op_ready      = run;
  assign bus.acc_idx       = acc_idx_q;
  assign bus.out_idx       = out_idx_q;
  assign bus.rst_accm_b    = rst_accm_b_q;
  assign bus.accm_en       = accm_en;
  assign bus.mux_accm_inp  = mux_accm_inp;
  // Reduction is combinational, so adder tree and SIPO fire on the final beat.
  assign bus.en_adder_tree = tree_en;
  assign bus.sipo_shift    = tree_en;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);

endmodule

// File: tb/tb_compute_seq.sv
module tb_compute_seq;
  localparam int COUNT = 128;
  localparam int ACC_W = 8;
  localparam int OUT_W = $clog2(COUNT) + 1;
  localparam int IDX_W = $clog2(COUNT);

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  compute_seq_if #(.COUNT(COUNT), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  compute_seq #(.COUNT(COUNT), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus.master)
  );

  // {op_ready, accm_en, mux_accm_inp, en_adder_tree, sipo_shift, busy, done, rst_accm_b}
  function automatic logic [7:0] outs();
    return {bus.op_ready, bus.accm_en, bus.mux_accm_inp, bus.en_adder_tree,
            bus.sipo_shift, bus.busy, bus.done, bus.rst_accm_b};
  endfunction

  // One launch, checked cycle by cycle against a beat-count model:
  // beat b (0-based) of a run is pass b%na of output b/na.
  // Entered and left at posedge+1 with the DUT idle; cycle 0 carries start.
  task automatic run_seq(input int na_in, input int no_in, input int vmode,
                         input int abort_cyc, input string nm,
                         output int beats, output int sipos,
                         output int done_cyc, output int max_out);
    int na, no, total, phase, b, cyc, e_acc, e_out;
    logic v, e_beat, e_last;
    logic [7:0] exp_o;
    bit aborted;
    na = (na_in == 0) ? 1 : na_in;
    no = (no_in == 0) ? 1 : ((no_in > COUNT) ? COUNT : no_in);
    total = na * no;
    phase = 0; b = 0; cyc = 0; aborted = 0;
    beats = 0; sipos = 0; done_cyc = -1; max_out = 0;
    // phase: 0 launch cycle, 1 clear, 2 run, 3 done, 4 back in idle
    while (phase != 4 && cyc < 4000) begin
      bus.abort = (cyc == abort_cyc);
      if (cyc == 0) begin
        bus.start   = 1'b1;
        bus.num_acc = ACC_W'(na_in);
        bus.num_out = OUT_W'(no_in);
      end else begin
        // junk launches and parameters while busy must change nothing
        bus.start   = 1'($urandom_range(0, 1));
        bus.num_acc = ACC_W'($urandom);
        bus.num_out = OUT_W'($urandom);
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (phase == 2) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.op_valid = v;
      e_acc = 0; e_out = 0;
      case (phase)
        1:  exp_o = 8'b0000_0100;
        2: begin
          e_acc  = b % na;
          e_out  = b / na;
          e_beat = v;
          e_last = v && (e_acc == na - 1);
          exp_o  = {1'b1, e_beat, 1'(e_acc != 0), e_last, e_last, 1'b1, 1'b0, 1'b1};
        end
        3:  exp_o = 8'b0000_0111;
        default: exp_o = 8'b0;
      endcase
      @(negedge clk);
      total_cnt++;
      if (outs() !== exp_o)
        $display("FAIL %s ctrl cyc%0d act=%b exp=%b", nm, cyc, outs(), exp_o);
      else pass_cnt++;
      if (phase == 1 || phase == 2) begin
        total_cnt++;
        if (bus.acc_idx !== ACC_W'(e_acc) || bus.out_idx !== IDX_W'(e_out))
          $display("FAIL %s idx cyc%0d act=%0d/%0d exp=%0d/%0d", nm, cyc,
                   bus.acc_idx, bus.out_idx, e_acc, e_out);
        else pass_cnt++;
      end
      if (bus.accm_en === 1'b1) beats++;
      if (bus.sipo_shift === 1'b1) sipos++;
      if (bus.done === 1'b1) done_cyc = cyc;
      if (int'(bus.out_idx) > max_out) max_out = int'(bus.out_idx);
      @(posedge clk); #1;
      if (cyc == abort_cyc) begin
        phase = 4; aborted = 1;
      end else begin
        case (phase)
          0: phase = 1;
          1: phase = 2;
          2: if (v) begin b++; if (b == total) phase = 3; end
          default: phase = 4;
        endcase
      end
      cyc++;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.op_valid = 1'b0;
    total_cnt++;
    if (phase != 4) $display("FAIL %s timeout act=phase%0d exp=phase4", nm, phase);
    else pass_cnt++;
    // first cycle after DONE / abort: idle, accumulator held in clear
    total_cnt++;
    if (outs() !== 8'b0) $display("FAIL %s post_idle act=%b exp=%b", nm, outs(), 8'b0);
    else pass_cnt++;
    if (aborted) begin
      total_cnt++;
      if (bus.acc_idx !== '0 || bus.out_idx !== '0)
        $display("FAIL %s abort_idx act=%0d/%0d exp=0/0", nm, bus.acc_idx, bus.out_idx);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.num_acc = '0; bus.num_out = '0; bus.op_valid = 1'b1;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (outs() !== 8'b0 || bus.acc_idx !== '0 || bus.out_idx !== '0)
      $display("FAIL reset_state act=%b/%0d/%0d exp=0/0/0", outs(), bus.acc_idx, bus.out_idx);
    else pass_cnt++;
    rst_b = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string nm, input int act, input int exp_v);
    total_cnt++;
    if (act !== exp_v) $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int bt, sp, dc, mo;
    run_seq(3, 2, 0, -1, "basic", bt, sp, dc, mo);
    check_int("basic_beats", bt, 6);
    check_int("basic_sipo", sp, 2);
    check_int("basic_done_cyc", dc, 8);
  endtask

  task automatic test_stall();
    int bt, sp, dc, mo;
    // valid at cycles 2,4,6,8 -> last beat at 8
    run_seq(2, 2, 1, -1, "stall", bt, sp, dc, mo);
    check_int("stall_beats", bt, 4);
    check_int("stall_sipo", sp, 2);
    check_int("stall_done_cyc", dc, 9);
  endtask

  task automatic test_degenerate();
    int bt, sp, dc, mo;
    run_seq(0, 0, 0, -1, "degen", bt, sp, dc, mo);
    check_int("degen_beats", bt, 1);
    check_int("degen_sipo", sp, 1);
    check_int("degen_done_cyc", dc, 3);
  endtask

  task automatic test_clamp();
    int bt, sp, dc, mo;
    run_seq(1, COUNT + 5, 2, -1, "clamp", bt, sp, dc, mo);
    check_int("clamp_sipo", sp, COUNT);
    check_int("clamp_max_out", mo, COUNT - 1);
  endtask

  task automatic test_abort();
    int bt, sp, dc, mo;
    // cycle 5 is beat 3: first pass of output 1
    run_seq(3, 3, 0, 5, "abort", bt, sp, dc, mo);
    check_int("abort_no_done", dc, -1);
    check_int("abort_beats", bt, 4);
    run_seq(2, 3, 0, -1, "after_abort", bt, sp, dc, mo);
    check_int("after_abort_done_cyc", dc, 8);
    check_int("after_abort_sipo", sp, 3);
  endtask

  task automatic test_back_to_back();
    int bt, sp, dc, mo;
    run_seq(2, 2, 0, -1, "b2b_a", bt, sp, dc, mo);
    run_seq(4, 1, 0, -1, "b2b_b", bt, sp, dc, mo);
    check_int("b2b_done_cyc", dc, 6);
  endtask

  task automatic test_random();
    int bt, sp, dc, mo, na, no, ab;
    for (int i = 0; i < 8; i++) begin
      na = $urandom_range(0, 5);
      no = $urandom_range(0, 6);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1;
      run_seq(na, no, 2, ab, "random", bt, sp, dc, mo);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.num_acc = ACC_W'(3); bus.num_out = OUT_W'(4); bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.accm_en !== 1'b1)
      $display("FAIL rst_mid_pre act=%b%b exp=11", bus.busy, bus.accm_en);
    else pass_cnt++;
    #2 rst_b = 1'b0;
    #1;
    total_cnt++;
    if (outs() !== 8'b0 || bus.acc_idx !== '0 || bus.out_idx !== '0)
      $display("FAIL rst_mid_now act=%b/%0d/%0d exp=0/0/0", outs(), bus.acc_idx, bus.out_idx);
    else pass_cnt++;
    bus.start = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (outs() !== 8'b0) $display("FAIL rst_mid_hold act=%b exp=%b", outs(), 8'b0);
    else pass_cnt++;
    bus.start = 1'b0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (outs() !== 8'b0) $display("FAIL rst_mid_release act=%b exp=%b", outs(), 8'b0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_degenerate();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    begin
      int bt, sp, dc, mo;
      run_seq(2, 2, 0, -1, "post_reset", bt, sp, dc, mo);
      check_int("post_reset_done_cyc", dc, 6);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
